// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall vectors,
// exception codes, FSM states and the codebase-wide reset/zero constants.
package pipe_ctrl_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Stall vectors: bit i holds pipeline register i; always a contiguous low run
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Exception codes committed by MEM
  localparam logic [31:0] EXC_INT          = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV           = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RECOVER  = 2'd1,
    ST_HALT_BUS = 2'd2
  } pipe_state_e;

  // Highest-priority stall request wins; later stages imply earlier ones
  function automatic logic [5:0] stall_select(input logic id, input logic ex,
                                              input logic mem);
    if (mem)     return STALL_MEM;
    else if (ex) return STALL_EX;
    else if (id) return STALL_ID;
    else         return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// MEM-stage data-bus watchdog: counts consecutive enabled cycles and emits a
// one-cycle expire pulse (registered) once STALL_TIMEOUT cycles have elapsed.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clr,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STALL_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Counter with clear priority; wraps to zero and pulses expire on the last count
  always_ff @(posedge clk) begin
    if (rst == RstEnable || clr) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (count_en && cnt == LAST_CNT) begin
      cnt    <= '0;
      expire <= 1'b1;
    end else if (count_en) begin
      cnt    <= cnt + CNT_W'(1);
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline control: merges stall requests into a per-stage stall
// vector, turns committed exceptions into flush + redirect PC, and watches
// for hung data-bus accesses (bus_err).
// Optional statistics counters are enabled by defining PIPE_STALL_STATS_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned STALL_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_err,
  output logic [1:0]  state_o
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  pipe_state_e state_q;
  pipe_state_e cur_state;
  pipe_state_e next_state;
  logic        exc_hit;
  logic        wd_count_en;
  logic        wd_expire;

  assign exc_hit = (excepttype != ZeroWord);

  // The watchdog pulse and the HALT_BUS entry share one edge: while the pulse
  // is high the unit already behaves as HALT_BUS, and state_q follows from there.
  assign cur_state = wd_expire ? ST_HALT_BUS : state_q;
  assign state_o   = cur_state;
  assign bus_err   = wd_expire;

  assign wd_count_en = (cur_state == ST_RUN) && stallreq_mem && !exc_hit;

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .count_en (wd_count_en),
    .clr      (!wd_count_en),
    .expire   (wd_expire)
  );

  // Combinational stall/flush/redirect and next-state selection
  always_comb begin
    stall      = STALL_NONE;
    flush      = 1'b0;
    new_pc     = ZeroWord;
    next_state = cur_state;
    case (cur_state)
      ST_RUN, ST_HALT_BUS: begin
        if (exc_hit) begin
          flush      = 1'b1;
          new_pc     = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
          next_state = ST_RECOVER;
        end else if (cur_state == ST_HALT_BUS) begin
          stall = STALL_MEM;
          if (!stallreq_mem) next_state = ST_RUN;
        end else begin
          stall = stall_select(stallreq_id, stallreq_ex, stallreq_mem);
        end
      end
      ST_RECOVER: next_state = ST_RUN;
      default:    next_state = ST_RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) state_q <= ST_RUN;
    else                  state_q <= next_state;
  end

`ifdef PIPE_STALL_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall != STALL_NONE && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (flush && flush_count != '1)                flush_count  <= flush_count + 16'd1;
    end
  end
`endif

endmodule
